iir_wb_master: RTL and testbench

Wishbone bus master that drives the IIR filter's Wishbone register interface from a sample stream. It accepts one input sample on a valid/ready stream, writes it to the filter's input register, and waits a programmable settle time for the filter pipeline. It then reads the filter's output register and presents the result on a valid/ready output stream. It sits between the sample source (ADC front end or test sequencer) and the IIR Wishbone slave, on the same clock.

---
 rtl/iir_pkg.sv | 17 +
 rtl/iir_wb_master.sv | 194 +++++++++++++++++++
 tb/tb_iir_wb_master.sv | 393 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/iir_pkg.sv
// Shared definitions for the IIR filter Wishbone master and slave:
// register map, default data width and the master FSM state encoding.
package iir_pkg;

   localparam int         IIR_DATA_WIDTH = 32;
   localparam logic [5:0] IIR_ADDR_X     = 6'h00;
   localparam logic [5:0] IIR_ADDR_Y     = 6'h04;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_WR     = 3'd1,
      ST_SETTLE = 3'd2,
      ST_RD     = 3'd3,
      ST_OUT    = 3'd4
   } wbm_state_e;

endpackage

// File: rtl/iir_wb_master.sv
// Wishbone master feeding the IIR filter register interface from a sample
// stream: write sample to X, wait SETTLE_CYCLES, read Y, present result.
// Optional ack watchdog enabled by defining IIR_WBM_TIMEOUT_EN.
module iir_wb_master
   import iir_pkg::*;
#(
   parameter int                      DATA_WIDTH     = IIR_DATA_WIDTH,
   parameter int                      ADDR_WIDTH     = 6,
   parameter logic [ADDR_WIDTH-1:0]   ADDR_X         = ADDR_WIDTH'(IIR_ADDR_X),
   parameter logic [ADDR_WIDTH-1:0]   ADDR_Y         = ADDR_WIDTH'(IIR_ADDR_Y),
   parameter int                      SETTLE_CYCLES  = 4,
   parameter int                      TIMEOUT_CYCLES = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ADDR_WIDTH-1:0] wb_adr_o,
   output logic [DATA_WIDTH-1:0] wb_dat_o,
   input  logic [DATA_WIDTH-1:0] wb_dat_i,
   output logic                  wb_we_o,
   output logic                  wb_stb_o,
   output logic                  wb_cyc_o,
   input  logic                  wb_ack_i,
   output logic                  err_o,
   output logic [15:0]           sample_cnt_o
);

   localparam int SW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

   wbm_state_e            state_q, state_d;
   logic [ADDR_WIDTH-1:0] adr_q, adr_d;
   logic [DATA_WIDTH-1:0] dat_q, dat_d;
   logic                  we_q, we_d;
   logic                  cyc_q, cyc_d;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic                  out_valid_q, out_valid_d;
   logic                  in_ready_q, in_ready_d;
   logic [15:0]           cnt_q, cnt_d;
   logic [SW-1:0]         settle_q, settle_d;
   logic                  timeout_hit;

`ifdef IIR_WBM_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TW-1:0] tmo_q;
   logic          err_q;

   assign timeout_hit = ((state_q == ST_WR) || (state_q == ST_RD)) && !wb_ack_i &&
                        (tmo_q == TW'(TIMEOUT_CYCLES - 1));

   // Ack watchdog: counts cycles spent in WR/RD, restarting on every state change
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_q <= '0;
         err_q <= 1'b0;
      end else begin
         if (state_d != state_q)
            tmo_q <= '0;
         else if ((state_q == ST_WR) || (state_q == ST_RD))
            tmo_q <= tmo_q + TW'(1);
         if (timeout_hit)
            err_q <= 1'b1;
      end
   end

   assign err_o = err_q;
`else
   logic unused_tmo_cfg;

   assign unused_tmo_cfg = (TIMEOUT_CYCLES == 0);
   assign timeout_hit    = 1'b0;
   assign err_o          = 1'b0;
`endif

   // Next-state and bus/stream register updates
   always_comb begin
      state_d     = state_q;
      adr_d       = adr_q;
      dat_d       = dat_q;
      we_d        = we_q;
      cyc_d       = cyc_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      cnt_d       = cnt_q;
      settle_d    = settle_q;
      unique case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               dat_d   = in_data;
               adr_d   = ADDR_X;
               we_d    = 1'b1;
               cyc_d   = 1'b1;
               state_d = ST_WR;
            end
         end
         ST_WR: begin
            if (wb_ack_i) begin
               we_d = 1'b0;
               // With no settle time the read strobe follows the write ack directly
               if (SETTLE_CYCLES == 0) begin
                  adr_d   = ADDR_Y;
                  cyc_d   = 1'b1;
                  state_d = ST_RD;
               end else begin
                  cyc_d    = 1'b0;
                  settle_d = SW'(SETTLE_CYCLES);
                  state_d  = ST_SETTLE;
               end
            end else if (timeout_hit) begin
               cyc_d   = 1'b0;
               we_d    = 1'b0;
               state_d = ST_IDLE;
            end
         end
         ST_SETTLE: begin
            if (settle_q <= SW'(1)) begin
               adr_d   = ADDR_Y;
               we_d    = 1'b0;
               cyc_d   = 1'b1;
               state_d = ST_RD;
            end else begin
               settle_d = settle_q - SW'(1);
            end
         end
         ST_RD: begin
            if (wb_ack_i) begin
               out_data_d  = wb_dat_i;
               out_valid_d = 1'b1;
               cyc_d       = 1'b0;
               state_d     = ST_OUT;
            end else if (timeout_hit) begin
               cyc_d   = 1'b0;
               state_d = ST_IDLE;
            end
         end
         ST_OUT: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               cnt_d       = cnt_q + 16'd1;
               state_d     = ST_IDLE;
            end
         end
         default: begin
            cyc_d   = 1'b0;
            we_d    = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
      in_ready_d = (state_d == ST_IDLE);
   end

   // State and registered outputs; reset aborts any bus cycle immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         adr_q       <= '0;
         dat_q       <= '0;
         we_q        <= 1'b0;
         cyc_q       <= 1'b0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b0;
         cnt_q       <= '0;
         settle_q    <= '0;
      end else begin
         state_q     <= state_d;
         adr_q       <= adr_d;
         dat_q       <= dat_d;
         we_q        <= we_d;
         cyc_q       <= cyc_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
         cnt_q       <= cnt_d;
         settle_q    <= settle_d;
      end
   end

   assign wb_adr_o     = adr_q;
   assign wb_dat_o     = dat_q;
   assign wb_we_o      = we_q;
   assign wb_cyc_o     = cyc_q;
   assign wb_stb_o     = cyc_q;
   assign out_data     = out_data_q;
   assign out_valid    = out_valid_q;
   assign in_ready     = in_ready_q;
   assign sample_cnt_o = cnt_q;

endmodule

// File: tb/tb_iir_wb_master.sv
// Bench for iir_wb_master. A behavioural IIR slave (y = x + y/2 on each
// write to X, read of Y returns y) answers the bus with programmable wait
// states; a separate arithmetic model predicts every output sample.
// Timeout scenario runs only when IIR_WBM_TIMEOUT_EN is defined.
module tb_iir_wb_master;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] in_data = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [5:0]  wb_adr_o;
   logic [31:0] wb_dat_o;
   logic [31:0] wb_dat_i;
   logic        wb_we_o, wb_stb_o, wb_cyc_o;
   logic        wb_ack;
   logic        err_o;
   logic [15:0] sample_cnt_o;

   int checks = 0;
   int failures = 0;

   iir_wb_master #(
      .DATA_WIDTH(32), .ADDR_WIDTH(6), .ADDR_X(6'h00), .ADDR_Y(6'h04),
      .SETTLE_CYCLES(4), .TIMEOUT_CYCLES(64)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
      .wb_we_o(wb_we_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
      .wb_ack_i(wb_ack), .err_o(err_o), .sample_cnt_o(sample_cnt_o)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural slave ----------------
   int unsigned       wait_n = 0;
   bit                no_ack = 1'b0;
   int unsigned       wcnt;
   logic signed [31:0] slave_y;
   bit                log_we[$];
   logic [5:0]        log_adr[$];
   logic [31:0]       log_dat[$];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_ack   <= 1'b0;
         wcnt     <= 0;
         slave_y  <= '0;
         wb_dat_i <= '0;
      end else if (wb_ack) begin
         wb_ack <= 1'b0;
      end else if (wb_cyc_o && wb_stb_o && !no_ack) begin
         if (wcnt >= wait_n) begin
            wb_ack <= 1'b1;
            wcnt   <= 0;
            log_we.push_back(wb_we_o);
            log_adr.push_back(wb_adr_o);
            if (wb_we_o) begin
               log_dat.push_back(wb_dat_o);
               if (wb_adr_o == 6'h00) slave_y <= $signed(wb_dat_o) + (slave_y >>> 1);
            end else begin
               log_dat.push_back(32'h0);
               wb_dat_i <= (wb_adr_o == 6'h04) ? slave_y : 32'hDEAD_BEEF;
            end
         end else begin
            wcnt <= wcnt + 1;
         end
      end
   end

   // ---------------- bus hold / pairing monitor ----------------
   int   stab_viol = 0;
   logic p_stb = 1'b0, p_ack = 1'b0, p_we = 1'b0;
   logic [5:0]  p_adr = '0;
   logic [31:0] p_dat = '0;

   always @(negedge clk) begin
      if (wb_cyc_o !== wb_stb_o) stab_viol++;
      if (rst_n && p_stb && !p_ack && wb_stb_o) begin
         if (wb_adr_o !== p_adr || wb_we_o !== p_we || (p_we && wb_dat_o !== p_dat))
            stab_viol++;
      end
      p_stb = wb_stb_o; p_ack = wb_ack; p_we = wb_we_o; p_adr = wb_adr_o; p_dat = wb_dat_o;
   end

   // ---------------- reference model ----------------
   logic signed [31:0] ref_y = '0;

   function automatic logic [31:0] model_step(input logic [31:0] x);
      ref_y = $signed(x) + (ref_y >>> 1);
      return ref_y;
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; no_ack = 1'b0; wait_n = 0;
      ref_y = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      log_we.delete(); log_adr.delete(); log_dat.delete();
      stab_viol = 0;
   endtask

   // Returns #1 after the accepting edge
   task automatic send_sample(input logic [31:0] x);
      int unsigned n = 0;
      @(negedge clk);
      in_data = x; in_valid = 1'b1;
      while (!in_ready && n < 300) begin @(negedge clk); n++; end
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++;
      if (n >= 300) begin
         failures++;
         $display("FAIL send_sample: in_ready never rose, waited=%0d limit=300", n);
      end
   endtask

   task automatic wait_output(output bit ok);
      int unsigned n = 0;
      @(negedge clk);
      while (!out_valid && n < 300) begin @(negedge clk); n++; end
      ok = (n < 300);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({in_ready, out_valid, wb_cyc_o, wb_stb_o, wb_we_o, err_o} !== 6'b0 ||
          sample_cnt_o !== 16'd0 || out_data !== 32'd0) begin
         failures++;
         $display("FAIL reset_outputs: got rdy=%b ov=%b cyc=%b stb=%b we=%b err=%b cnt=%0d od=%0h expected all zero",
                  in_ready, out_valid, wb_cyc_o, wb_stb_o, wb_we_o, err_o, sample_cnt_o, out_data);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_in_ready: got %b expected 1", in_ready);
      end
   endtask

   task automatic test_single();
      logic [31:0] exp;
      int unsigned k = 0;
      apply_reset();
      exp = model_step(32'd1000);
      send_sample(32'd1000);
      @(negedge clk);
      checks++;
      if (!(wb_stb_o && wb_cyc_o && wb_we_o && wb_adr_o == 6'h00 && wb_dat_o == 32'd1000 && !in_ready)) begin
         failures++;
         $display("FAIL single_write_phase: got stb=%b we=%b adr=%0h dat=%0d rdy=%b expected 1,1,00,1000,0",
                  wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, in_ready);
      end
      while (!out_valid && k < 50) begin @(posedge clk); k++; @(negedge clk); end
      checks++;
      if (k !== 8) begin
         failures++;
         $display("FAIL single_latency: got %0d cycles expected 8", k);
      end
      checks++;
      if (out_data !== exp) begin
         failures++;
         $display("FAIL single_data: got %0d expected %0d", $signed(out_data), $signed(exp));
      end
      checks++;
      if (log_we.size() != 2 || log_we[0] != 1'b1 || log_adr[0] != 6'h00 || log_dat[0] != 32'd1000 ||
          log_we[1] != 1'b0 || log_adr[1] != 6'h04) begin
         failures++;
         $display("FAIL single_bus_seq: got %0d transfers expected write 00/1000 then read 04", log_we.size());
      end
      out_ready = 1'b1;
      @(posedge clk); #1; out_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (sample_cnt_o !== 16'd1 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL single_handshake: got cnt=%0d ov=%b rdy=%b expected 1,0,1", sample_cnt_o, out_valid, in_ready);
      end
   endtask

   task automatic test_impulse();
      logic [31:0] x, exp;
      bit ok;
      int bad = 0;
      apply_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 32; i++) begin
         x = (i == 0) ? 32'd1 << 20 : 32'd0;
         exp = model_step(x);
         send_sample(x);
         wait_output(ok);
         checks++;
         if (!ok || out_data !== exp) begin
            failures++; bad++;
            $display("FAIL impulse_out[%0d]: got %0d expected %0d (valid_seen=%0d)", i, $signed(out_data), $signed(exp), ok);
         end
      end
      @(negedge clk);
      out_ready = 1'b0;
      checks++;
      if (sample_cnt_o !== 16'd32) begin
         failures++;
         $display("FAIL impulse_count: got %0d expected 32", sample_cnt_o);
      end
      checks++;
      if (stab_viol != 0) begin
         failures++;
         $display("FAIL impulse_bus_hold: got %0d violations expected 0", stab_viol);
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] exp;
      bit ok;
      int n0;
      int bad = 0;
      exp = model_step(32'h0001_2345);
      send_sample(32'h0001_2345);
      wait_output(ok);
      n0 = log_we.size();
      in_data = 32'h7777; in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (out_valid !== 1'b1 || out_data !== exp || in_ready !== 1'b0 || wb_cyc_o !== 1'b0) bad++;
      end
      checks++;
      if (!ok || bad != 0 || log_we.size() != n0) begin
         failures++;
         $display("FAIL backpressure_hold: got %0d bad cycles, %0d extra transfers, data=%0h expected 0,0,%0h",
                  bad, log_we.size() - n0, out_data, exp);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1; out_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (sample_cnt_o !== 16'd33) begin
         failures++;
         $display("FAIL backpressure_count: got %0d expected 33", sample_cnt_o);
      end
   endtask

   task automatic test_wait_states();
      logic [31:0] exp;
      bit ok;
      int n0;
      wait_n = 3;
      stab_viol = 0;
      n0 = log_we.size();
      exp = model_step(32'hFFFF_F000);
      send_sample(32'hFFFF_F000);
      wait_output(ok);
      checks++;
      if (!ok || out_data !== exp) begin
         failures++;
         $display("FAIL waitstate_data: got %0h expected %0h", out_data, exp);
      end
      checks++;
      if (stab_viol != 0 || log_we.size() != n0 + 2) begin
         failures++;
         $display("FAIL waitstate_bus: got viol=%0d transfers=%0d expected 0 and 2", stab_viol, log_we.size() - n0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1; out_ready = 1'b0;
      wait_n = 0;
   endtask

   task automatic test_random();
      logic [31:0] x, exp;
      bit ok;
      logic [15:0] cnt0;
      apply_reset();
      cnt0 = sample_cnt_o;
      for (int i = 0; i < 20; i++) begin
         wait_n = $urandom_range(0, 3);
         x = $urandom;
         exp = model_step(x);
         send_sample(x);
         wait_output(ok);
         checks++;
         if (!ok || out_data !== exp) begin
            failures++;
            $display("FAIL random_out[%0d]: got %0h expected %0h", i, out_data, exp);
         end
         repeat ($urandom_range(0, 3)) @(negedge clk);
         out_ready = 1'b1;
         @(posedge clk); #1; out_ready = 1'b0;
      end
      @(negedge clk);
      checks++;
      if (sample_cnt_o !== cnt0 + 16'd20 || stab_viol != 0) begin
         failures++;
         $display("FAIL random_count: got cnt=%0d viol=%0d expected %0d and 0", sample_cnt_o, stab_viol, cnt0 + 16'd20);
      end
      wait_n = 0;
   endtask

   task automatic test_reset_in_rd();
      int unsigned n = 0;
      wait_n = 3;
      send_sample(32'd55);
      @(negedge clk);
      while (!(wb_stb_o && !wb_we_o) && n < 100) begin @(negedge clk); n++; end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (n >= 100 || wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_in_rd: got cyc=%b stb=%b ov=%b reached_rd=%0d expected 0,0,0,1",
                  wb_cyc_o, wb_stb_o, out_valid, n < 100);
      end
      @(negedge clk);
      rst_n = 1'b1;
      wait_n = 0;
      ref_y = '0;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || sample_cnt_o !== 16'd0 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_in_rd_release: got rdy=%b cnt=%0d ov=%b expected 1,0,0", in_ready, sample_cnt_o, out_valid);
      end
   endtask

`ifdef IIR_WBM_TIMEOUT_EN
   task automatic test_timeout();
      int unsigned n = 0;
      int extra = 0;
      logic [31:0] exp;
      bit ok;
      apply_reset();
      no_ack = 1'b1;
      send_sample(32'd99);
      @(negedge clk);
      while (wb_cyc_o && n < 200) begin @(negedge clk); n++; end
      checks++;
      if (n != 64 || err_o !== 1'b1) begin
         failures++;
         $display("FAIL timeout_abort: got cyc_cycles=%0d err=%b expected 64 and 1", n, err_o);
      end
      no_ack = 1'b0;
      repeat (5) begin @(negedge clk); if (out_valid) extra++; end
      checks++;
      if (extra != 0 || sample_cnt_o !== 16'd0 || log_we.size() != 0) begin
         failures++;
         $display("FAIL timeout_discard: got ov_cycles=%0d cnt=%0d transfers=%0d expected 0,0,0", extra, sample_cnt_o, log_we.size());
      end
      exp = model_step(32'd321);
      send_sample(32'd321);
      wait_output(ok);
      checks++;
      if (!ok || out_data !== exp || err_o !== 1'b1) begin
         failures++;
         $display("FAIL timeout_recover: got data=%0d err=%b expected %0d and sticky 1", out_data, err_o, exp);
      end
      out_ready = 1'b1;
      @(posedge clk); #1; out_ready = 1'b0;
   endtask
`endif

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation exceeded 500000 time units");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_single();
      test_impulse();
      test_backpressure();
      test_wait_states();
      test_random();
      test_reset_in_rd();
`ifdef IIR_WBM_TIMEOUT_EN
      test_timeout();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
